// File: rtl/tv80_alu16_seq_if.sv
// tv80_alu16_seq_if: bundles the core request/response and ALU-side signals of the
// 16-bit sequencer. master = core/ALU environment, slave = the sequencer.
interface tv80_alu16_seq_if;
  // Core request
  logic        start;
  logic [1:0]  op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [7:0]  f_in;
  // Core response
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [7:0]  f_out;
  // ALU drive
  logic [3:0]  alu_op;
  logic        alu_arith16;
  logic        alu_z16;
  logic [7:0]  alu_busa;
  logic [7:0]  alu_busb;
  logic [7:0]  alu_f_in;
  // ALU return
  logic [7:0]  alu_q;
  logic [7:0]  alu_f_out;

  modport master (
    output start, op, opa, opb, f_in, alu_q, alu_f_out,
    input  busy, done, result, f_out,
    input  alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_f_in
  );

  modport slave (
    input  start, op, opa, opb, f_in, alu_q, alu_f_out,
    output busy, done, result, f_out,
    output alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_f_in
  );
endinterface

// File: rtl/tv80_alu16_seq.sv
// tv80_alu16_seq: runs 16-bit ADD/ADC/SBC HL,rr as two byte passes (low, then high)
// through the 8-bit tv80_alu, then returns the 16-bit result and final F.
// Optional feature macro: TV80_ALU16_CMP_EN -- op=11 becomes CP16 (flags only);
// without it op=11 behaves as ADD.
module tv80_alu16_seq #(
  parameter int unsigned Flag_C = 0,
  parameter int unsigned Flag_N = 1,
  parameter int unsigned Flag_P = 2,
  parameter int unsigned Flag_X = 3,
  parameter int unsigned Flag_H = 4,
  parameter int unsigned Flag_Y = 5,
  parameter int unsigned Flag_Z = 6,
  parameter int unsigned Flag_S = 7
) (
  input logic             clk,
  input logic             reset_n,
  input logic             cen,
  tv80_alu16_seq_if.slave bus
);

  // The sequencer only forwards F between passes, but the map must agree with the ALU.
  localparam logic [7:0] FlagMask = 8'(1 << Flag_C) | 8'(1 << Flag_N) | 8'(1 << Flag_P) |
                                    8'(1 << Flag_X) | 8'(1 << Flag_H) | 8'(1 << Flag_Y) |
                                    8'(1 << Flag_Z) | 8'(1 << Flag_S);
  if (FlagMask != 8'hFF) begin : gen_bad_flag_map
    $error("tv80_alu16_seq: Flag_* positions must be distinct and below 8");
  end

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  flag_q, flag_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  f_out_q, f_out_d;

  logic       is_add;
  logic       is_cmp;
  logic [3:0] op_lo;
  logic [3:0] op_hi;

  logic [3:0] alu_op;
  logic       alu_arith16;
  logic       alu_z16;
  logic [7:0] alu_busa;
  logic [7:0] alu_busb;
  logic [7:0] alu_f_in;

  // Decode the latched opcode into per-pass ALU opcodes.
  always_comb begin
`ifdef TV80_ALU16_CMP_EN
    is_cmp = (op_q == 2'b11);
`else
    is_cmp = 1'b0;
`endif
    is_add = (op_q == 2'b00) || ((op_q == 2'b11) && !is_cmp);
    op_lo  = 4'b0000;
    op_hi  = 4'b0001;
    if (is_cmp) begin
      op_lo = 4'b0010;
      op_hi = 4'b0011;
    end else if (op_q == 2'b01) begin
      op_lo = 4'b0001;
      op_hi = 4'b0001;
    end else if (op_q == 2'b10) begin
      op_lo = 4'b0011;
      op_hi = 4'b0011;
    end
  end

  // Next-state, register updates and ALU drive for each pass.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    flag_d      = flag_q;
    lo_d        = lo_q;
    result_d    = result_q;
    f_out_d     = f_out_q;
    alu_op      = 4'b0000;
    alu_arith16 = 1'b0;
    alu_z16     = 1'b0;
    alu_busa    = 8'h00;
    alu_busb    = 8'h00;
    alu_f_in    = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.opa;
          b_d     = bus.opb;
          op_d    = bus.op;
          flag_d  = bus.f_in;
          state_d = StLo;
        end
      end
      StLo: begin
        alu_op      = op_lo;
        alu_arith16 = is_add;
        alu_busa    = a_q[7:0];
        alu_busb    = b_q[7:0];
        alu_f_in    = flag_q;
        lo_d        = bus.alu_q;
        flag_d      = bus.alu_f_out;
        state_d     = StHi;
      end
      StHi: begin
        // Z16 lets the high pass AND its zero test with the low pass's Z.
        alu_op      = op_hi;
        alu_arith16 = is_add;
        alu_z16     = 1'b1;
        alu_busa    = a_q[15:8];
        alu_busb    = b_q[15:8];
        alu_f_in    = flag_q;
        f_out_d     = bus.alu_f_out;
        if (!is_cmp) begin
          result_d = {bus.alu_q, lo_q};
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register: synchronous active-low reset, advances only on cen.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      op_q     <= 2'b00;
      flag_q   <= 8'h00;
      lo_q     <= 8'h00;
      result_q <= 16'h0000;
      f_out_q  <= 8'h00;
    end else if (cen) begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      flag_q   <= flag_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      f_out_q  <= f_out_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.result      = result_q;
  assign bus.f_out       = f_out_q;
  assign bus.alu_op      = alu_op;
  assign bus.alu_arith16 = alu_arith16;
  assign bus.alu_z16     = alu_z16;
  assign bus.alu_busa    = alu_busa;
  assign bus.alu_busb    = alu_busb;
  assign bus.alu_f_in    = alu_f_in;

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// tb_tv80_alu16_seq: drives the sequencer with a byte-level tv80_alu stand-in and checks
// results against directed vectors and a 16-bit arithmetic reference model.
module tb_tv80_alu16_seq;

  logic clk;
  logic reset_n;
  logic cen;
  int   checks;
  int   errors;
  logic [15:0] exp_result;

  tv80_alu16_seq_if bus ();

  tv80_alu16_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cen     (cen),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte ALU stand-in: tv80_alu behaviour for ALU_Op 0000..0011 with Arith16/Z16.
  function automatic logic [15:0] alu8(input logic [3:0] aop, input logic ar16,
                                       input logic z16, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] fi);
    logic       sub;
    logic       cin;
    logic [7:0] bb;
    logic [8:0] s;
    logic [4:0] h;
    logic [7:0] s7;
    logic [7:0] q;
    logic [7:0] fo;
    sub = aop[1];
    cin = sub ^ (aop[0] & ~aop[2] & fi[0]);
    bb  = sub ? ~b : b;
    s   = {1'b0, a} + {1'b0, bb} + {8'h00, cin};
    h   = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + {4'h0, cin};
    s7  = {1'b0, a[6:0]} + {1'b0, bb[6:0]} + {7'h00, cin};
    q   = s[7:0];
    fo    = fi;
    fo[0] = sub ? ~s[8] : s[8];
    fo[1] = sub;
    fo[4] = sub ? ~h[4] : h[4];
    fo[2] = s[8] ^ s7[7];
    fo[3] = q[3];
    fo[5] = q[5];
    fo[6] = (q == 8'h00) ? (z16 ? fi[6] : 1'b1) : 1'b0;
    fo[7] = q[7];
    if (ar16) begin
      fo[7] = fi[7];
      fo[6] = fi[6];
      fo[2] = fi[2];
    end
    return {fo, q};
  endfunction

  always_comb begin
    {bus.alu_f_out, bus.alu_q} = alu8(bus.alu_op, bus.alu_arith16, bus.alu_z16,
                                      bus.alu_busa, bus.alu_busb, bus.alu_f_in);
  end

  // 16-bit reference: returns {f, result} from whole-word arithmetic.
  function automatic logic [23:0] ref16(input logic [1:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [7:0] fi,
                                        input logic [15:0] prev);
    logic [16:0] full;
    logic [15:0] r;
    logic [7:0]  f;
    logic        c;
    logic        cmp;
    c   = fi[0];
    f   = 8'h00;
`ifdef TV80_ALU16_CMP_EN
    cmp = (op == 2'b11);
`else
    cmp = 1'b0;
`endif
    if (op == 2'b00 || (op == 2'b11 && !cmp)) begin
      full = {1'b0, a} + {1'b0, b};
      r    = full[15:0];
      f    = fi & 8'hC4;
      f[0] = full[16];
      f[4] = ({1'b0, a[11:0]} + {1'b0, b[11:0]}) > 13'h0FFF;
    end else if (op == 2'b01) begin
      full = {1'b0, a} + {1'b0, b} + {16'h0000, c};
      r    = full[15:0];
      f[0] = full[16];
      f[4] = ({1'b0, a[11:0]} + {1'b0, b[11:0]} + {12'h000, c}) > 13'h0FFF;
      f[2] = (a[15] == b[15]) && (r[15] != a[15]);
      f[6] = (r == 16'h0000);
      f[7] = r[15];
    end else begin
      if (cmp) c = 1'b0;
      full = {1'b0, a} - {1'b0, b} - {16'h0000, c};
      r    = full[15:0];
      f[0] = full[16];
      f[1] = 1'b1;
      f[4] = {1'b0, a[11:0]} < ({1'b0, b[11:0]} + {12'h000, c});
      f[2] = (a[15] != b[15]) && (r[15] != a[15]);
      f[6] = (r == 16'h0000);
      f[7] = r[15];
    end
    f[3] = r[11];
    f[5] = r[13];
    if (cmp) r = prev;
    return {f, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One transaction with full checking; ers/efs are the required result and flags.
  task automatic run_op(input string name, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [7:0] fi,
                        input logic [15:0] ers, input logic [7:0] efs);
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    bus.f_in  = fi;
    @(negedge clk);
    bus.start = 1'b0;
    // Scramble operands after acceptance: the DUT must have captured them.
    bus.op    = 2'($urandom);
    bus.opa   = 16'($urandom);
    bus.opb   = 16'($urandom);
    bus.f_in  = 8'($urandom);
    lat = 1;
    while (!bus.done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({name, ".latency"}, lat, 3);
    check({name, ".busy"}, {31'd0, bus.busy}, 1);
    check({name, ".result"}, {16'd0, bus.result}, {16'd0, ers});
    check({name, ".f_out"}, {24'd0, bus.f_out}, {24'd0, efs});
    exp_result = ers;
    @(negedge clk);
    check({name, ".idle"}, {30'd0, bus.busy, bus.done}, 0);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  fi;
    logic [15:0] er;
    logic [7:0]  ef;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          dcount;
    logic [1:0]  rop;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [7:0]  rf;
    logic [23:0] e;

    checks     = 0;
    errors     = 0;
    exp_result = 16'h0000;
    reset_n    = 1'b0;
    cen        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.opa    = 16'h0000;
    bus.opb    = 16'h0000;
    bus.f_in   = 8'h00;

    vecs[0] = '{"add_h", 2'b00, 16'h0FFF, 16'h0001, 8'hC5, 16'h1000, 8'hD4};
    vecs[1] = '{"adc_wrap", 2'b01, 16'hFFFF, 16'h0000, 8'h01, 16'h0000, 8'h51};
    vecs[2] = '{"sbc_ovf", 2'b10, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 8'h3E};
    vecs[3] = '{"sbc_zero", 2'b10, 16'h1234, 16'h1234, 8'h00, 16'h0000, 8'h42};
    vecs[4] = '{"add_carry", 2'b00, 16'h8000, 16'h8000, 8'h00, 16'h0000, 8'h01};
    vecs[5] = '{"sbc_lozero", 2'b10, 16'h1200, 16'h1100, 8'h00, 16'h0100, 8'h02};
`ifdef TV80_ALU16_CMP_EN
    vecs[6] = '{"cp16_eq", 2'b11, 16'h1234, 16'h1234, 8'h00, 16'h0100, 8'h42};
`else
    vecs[6] = '{"op3_add", 2'b11, 16'h1234, 16'h1234, 8'h00, 16'h2468, 8'h20};
`endif

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset.busy", {31'd0, bus.busy}, 0);
    check("reset.done", {31'd0, bus.done}, 0);
    check("reset.result", {16'd0, bus.result}, 0);
    check("reset.f_out", {24'd0, bus.f_out}, 0);
    check("reset.alu_op", {28'd0, bus.alu_op}, 0);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fi,
             vecs[i].er, vecs[i].ef);
    end

    // cen held low for 5 clocks during the high pass.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.opa   = 16'h8000;
    bus.opb   = 16'h0001;
    bus.f_in  = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    cen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall.busa", {24'd0, bus.alu_busa}, 32'h80);
      check("stall.busb", {24'd0, bus.alu_busb}, 32'h00);
      check("stall.op_z16", {27'd0, bus.alu_op, bus.alu_z16}, {27'd0, 4'b0011, 1'b1});
      check("stall.done", {31'd0, bus.done}, 0);
    end
    cen = 1'b1;
    @(negedge clk);
    check("stall.done_after", {31'd0, bus.done}, 1);
    check("stall.result", {16'd0, bus.result}, 32'h7FFF);
    check("stall.f_out", {24'd0, bus.f_out}, 32'h3E);
    @(negedge clk);

    // start held through LO/HI/DONE is ignored; a single completion results.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.opa   = 16'h0001;
    bus.opb   = 16'h0001;
    bus.f_in  = 8'h00;
    @(negedge clk);
    bus.opa   = 16'hFFFF;
    bus.opb   = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    check("busy_start.done", {31'd0, bus.done}, 1);
    check("busy_start.result", {16'd0, bus.result}, 32'h0002);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_start.idle", {31'd0, bus.busy}, 0);
    dcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    check("busy_start.no_extra_done", dcount, 0);
    exp_result = 16'h0002;

    // Reset while in the high pass aborts without writing a result.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.opa   = 16'h1111;
    bus.opb   = 16'h2222;
    bus.f_in  = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_hi.busy_done", {30'd0, bus.busy, bus.done}, 0);
    check("rst_hi.result", {16'd0, bus.result}, 0);
    check("rst_hi.f_out", {24'd0, bus.f_out}, 0);
    reset_n    = 1'b1;
    exp_result = 16'h0000;

    // Randomised transactions against the 16-bit reference model.
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rf  = 8'($urandom);
      if (n % 8 == 0) rb = ra;
      if (n % 8 == 1) ra = 16'hFFFF;
      e = ref16(rop, ra, rb, rf, exp_result);
      run_op($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb, rf, e[15:0], e[23:16]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
